uart_tx_arbiter: RTL

- Round-robin scheduler that shares one uart_tx frame transmitter between NUM_REQ requesters.
- Accepts one packed frame word at a time and validates its length field.
- Presents each accepted word to uart_tx through a valid/ready handshake.
- Holds off all other requesters until uart_tx has finished the whole frame, then enforces a programmable inter-frame idle gap.

---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ requesters; checks frame length.
// Latency: requester handshake to tx_valid is 1 cycle; next handshake GAP_CYCLES+1 cycles after tx_ready rises.
// Backpressure: req_ready is raised only in IDLE; OFFER waits on tx_ready indefinitely.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int FULL_DATA_SIZE = 40,
  parameter int BYTE_SIZE      = 8,
  parameter int GAP_CYCLES     = 16,
  localparam int ID_W          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_REQ*FULL_DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [FULL_DATA_SIZE-1:0]         tx_data,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic                              busy,
  output logic [ID_W-1:0]                   grant_id,
  output logic                              frame_done,
  output logic                              drop,
  output logic [ID_W-1:0]                   drop_id
);

  localparam int MAX_LEN  = (FULL_DATA_SIZE - 2*BYTE_SIZE) / BYTE_SIZE;
  localparam int LEN_LSB  = FULL_DATA_SIZE - 2*BYTE_SIZE;
  localparam int CNT_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OFFER     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [ID_W-1:0]           last_grant;
  logic [ID_W-1:0]           sel;
  logic                      sel_found;
  logic [FULL_DATA_SIZE-1:0] words [NUM_REQ];
  logic [FULL_DATA_SIZE-1:0] sel_word;
  logic [BYTE_SIZE-1:0]      sel_len;
  logic                      len_ok;
  logic                      accept;
  logic                      frame_end;
  logic [CNT_W-1:0]          gap_cnt;

  // Unpack the flat request bus into one word per requester
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign words[g] = req_data[g*FULL_DATA_SIZE +: FULL_DATA_SIZE];
  end

  // Round-robin search: requesters above last_grant first, then wrap to the bottom
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req_valid[i] && (ID_W'(i) > last_grant)) begin
        sel       = ID_W'(i);
        sel_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req_valid[i]) begin
        sel       = ID_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Length byte of the selected word must lie in 1..MAX_LEN
  always_comb begin
    sel_word = words[sel];
    sel_len  = sel_word[LEN_LSB +: BYTE_SIZE];
    len_ok   = (sel_len != '0) && (sel_len <= BYTE_SIZE'(MAX_LEN));
  end

  // Next-state and handshake decode; req_ready is held low while RST is asserted
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found && !RST) begin
          req_ready[sel] = 1'b1;
          accept         = 1'b1;
          if (len_ok) begin
            state_nxt = OFFER;
          end
        end
      end
      OFFER: begin
        if (tx_ready) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          frame_end = 1'b1;
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word latch, grant bookkeeping, status pulses and inter-frame gap counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      frame_done <= 1'b0;
      drop       <= 1'b0;
      drop_id    <= '0;
      gap_cnt    <= '0;
    end else begin
      frame_done <= frame_end;
      drop       <= accept && !len_ok;
      if (accept) begin
        tx_data    <= sel_word;
        grant_id   <= sel;
        last_grant <= sel;
        if (!len_ok) begin
          drop_id <= sel;
        end
      end
      if (frame_end) begin
        gap_cnt <= CNT_W'(GAP_LOAD);
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - CNT_W'(1);
      end
    end
  end

  // tx_valid follows OFFER so tx_data is stable for the whole offer
  assign tx_valid = (state == OFFER);
  assign busy     = (state != IDLE);

endmodule
